// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Readback path for a multiplexed common-anode 7-segment display. The block
// synchronizes the anode and segment lines and waits for them to stay stable.
// It then decodes the active-low segment pattern into a digit and stores that
// digit in the register for the active position. It also reports when every
// position has been refreshed at least once, which marks a complete frame.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [6:0]                    seg,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          update,
  output logic [$clog2(NUM_DIGITS)-1:0] update_pos,
  output logic                          bad_pattern,
  output logic                          frame_done
);

  localparam int POS_W = $clog2(NUM_DIGITS);
  localparam int LOW_W = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [LOW_W-1:0] LOW_ONE  = LOW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,    // anode state illegal: nothing to watch
    S_SETTLE,  // legal anode state, counting identical samples
    S_HELD     // this dwell has already been captured
  } state_t;

  // Synchronizer stages, plus the previous stage-2 sample for change detection
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [6:0]            seg_s1, seg_s2, seg_prev;

  // Anode decode
  logic [LOW_W-1:0]      low_cnt;
  logic [POS_W-1:0]      cand_pos;
  logic                  an_legal;

  // Segment decode
  logic [3:0]            dec_digit;
  logic                  dec_bad;

  // Dwell tracking
  state_t                state, state_n;
  logic [CNT_W-1:0]      count, count_n;
  logic                  changed;
  logic                  capture;

  // Frame tracking
  logic [NUM_DIGITS-1:0] seen, seen_set, seen_n, pos_mask;
  logic                  frame_hit;

  // Two-flop synchronizer on the asynchronous display lines; also keeps last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its old neighbour;
      // blocking ones would collapse the chain into a single flop.
      an_s1    <= an;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= seg;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  // Anode decode: legal only when exactly one line is driven low
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    low_cnt  = '0;
    cand_pos = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s2[i]) begin
        low_cnt  = low_cnt + 1'b1;
        cand_pos = POS_W'(i);
      end
    end
    an_legal = (low_cnt == LOW_ONE);
  end

  // Map the active-low segment pattern back to a digit; unknown patterns flag bad
  always_comb begin
    dec_digit = 4'hE;
    dec_bad   = 1'b1;
    case (seg_s2)
      7'b1000000: begin dec_digit = 4'h0; dec_bad = 1'b0; end
      7'b1111001: begin dec_digit = 4'h1; dec_bad = 1'b0; end
      7'b0100100: begin dec_digit = 4'h2; dec_bad = 1'b0; end
      7'b0110000: begin dec_digit = 4'h3; dec_bad = 1'b0; end
      7'b0011001: begin dec_digit = 4'h4; dec_bad = 1'b0; end
      7'b0010010: begin dec_digit = 4'h5; dec_bad = 1'b0; end
      7'b0000010: begin dec_digit = 4'h6; dec_bad = 1'b0; end
      7'b1111000: begin dec_digit = 4'h7; dec_bad = 1'b0; end
      7'b0000000: begin dec_digit = 4'h8; dec_bad = 1'b0; end
      7'b0010000: begin dec_digit = 4'h9; dec_bad = 1'b0; end
      7'b1111111: begin dec_digit = 4'hF; dec_bad = 1'b0; end
      default:    begin dec_digit = 4'hE; dec_bad = 1'b1; end
    endcase
  end

  assign changed = ({an_s2, seg_s2} != {an_prev, seg_prev});

  // Dwell state and stability counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= CNT_ZERO;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Next-state logic: count identical samples and capture once per dwell
  always_comb begin
    state_n = state;
    count_n = count;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (an_legal) begin
          state_n = S_SETTLE;
          count_n = CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (changed) begin
          state_n = an_legal ? S_SETTLE : S_IDLE;
          count_n = an_legal ? CNT_ONE : CNT_ZERO;
        end else if (count == CNT_LAST) begin
          capture = 1'b1;
          state_n = S_HELD;
          count_n = CNT_FULL;
        end else begin
          count_n = count + 1'b1;
        end
      end
      S_HELD: begin
        if (changed) begin
          state_n = an_legal ? S_SETTLE : S_IDLE;
          count_n = an_legal ? CNT_ONE : CNT_ZERO;
        end
      end
      default: begin
        state_n = S_IDLE;
        count_n = CNT_ZERO;
      end
    endcase
  end

  // Frame tracking: a frame closes on the capture that completes the seen mask
  always_comb begin
    pos_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pos_mask[i] = (cand_pos == POS_W'(i));
    end
    seen_set  = seen;
    frame_hit = 1'b0;
    if (capture) begin
      seen_set  = seen | pos_mask;
      frame_hit = &seen_set;
    end
    // The capture that closes a frame does not count toward the next frame
    seen_n = frame_hit ? '0 : seen_set;
  end

  // Output registers: digit bank, valid flags, and the one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the digit bank is a handful of flops, not a RAM, so it is reset
      // to blank and readback never shows garbage before the first capture.
      digits      <= '1;
      digit_valid <= '0;
      update      <= 1'b0;
      update_pos  <= '0;
      bad_pattern <= 1'b0;
      frame_done  <= 1'b0;
      seen        <= '0;
    end else begin
      update      <= capture;
      update_pos  <= capture ? cand_pos : '0;
      bad_pattern <= capture & dec_bad;
      frame_done  <= frame_hit;
      seen        <= seen_n;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && pos_mask[i]) begin
          digits[4*i +: 4] <= dec_digit;
          digit_valid[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
// Self-checking bench for seg_scan_decoder. The reference model treats a
// capture as the moment a legal {an,seg} value has persisted for exactly
// STABLE_CYCLES synchronized samples. It finds the digit by looking up the
// segment pattern in a code table.
module tb_seg_scan_decoder;

  localparam int N  = 6;
  localparam int SC = 4;
  localparam int PW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_valid;
  logic           update;
  logic [PW-1:0]  update_pos;
  logic           bad_pattern;
  logic           frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .update_pos  (update_pos),
    .bad_pattern (bad_pattern),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Segment code for digits 0..9, active-low, bit0 = a
  logic [6:0] code_tbl [10];

  // ---------------- reference model ----------------
  logic [N+6:0]   m_s1, m_s2;   // input one and two edges ago
  int             m_run;        // length of the current run of identical samples
  logic [4*N-1:0] m_digits;
  logic [N-1:0]   m_valid;
  logic [N-1:0]   m_seen;
  logic           m_update, m_bad, m_frame;
  logic [PW-1:0]  m_pos;

  function automatic logic [3:0] ref_digit(input logic [6:0] s);
    if (s == 7'b1111111) return 4'hF;
    for (int i = 0; i < 10; i++)
      if (code_tbl[i] == s) return 4'(i);
    return 4'hE;
  endfunction

  function automatic int low_pos(input logic [N-1:0] a);
    for (int i = 0; i < N; i++)
      if (!a[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1     = '1;
    m_s2     = '1;
    m_run    = SC + 1;
    m_digits = '1;
    m_valid  = '0;
    m_seen   = '0;
    m_update = 1'b0;
    m_bad    = 1'b0;
    m_frame  = 1'b0;
    m_pos    = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] a, input logic [6:0] s);
    logic [N-1:0] a2;
    logic [6:0]   s2;
    logic [3:0]   d;
    int           p;
    a2 = m_s2[N+6:7];
    s2 = m_s2[6:0];
    m_update = 1'b0;
    m_bad    = 1'b0;
    m_frame  = 1'b0;
    m_pos    = '0;
    if ($countones(~a2) == 1 && m_run == SC) begin
      p = low_pos(a2);
      d = ref_digit(s2);
      m_digits[4*p +: 4] = d;
      m_valid[p] = 1'b1;
      m_update   = 1'b1;
      m_pos      = PW'(p);
      m_bad      = (d == 4'hE);
      m_seen[p]  = 1'b1;
      if (&m_seen) begin
        m_frame = 1'b1;
        m_seen  = '0;
      end
    end
    if (m_s1 == m_s2) m_run = (m_run < SC + 1) ? m_run + 1 : m_run;
    else              m_run = 1;
    m_s2 = m_s1;
    m_s1 = {a, s};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("digits",      32'(digits),      32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("update",      32'(update),      32'(m_update));
    check("update_pos",  32'(update_pos),  32'(m_pos));
    check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
    check("frame_done",  32'(frame_done),  32'(m_frame));
  endtask

  // Per-hold observations
  int             cyc_i, first_upd, n_upd, n_bad, n_frame;
  logic [PW-1:0]  upd_pos_q;
  logic           upd_bad_q, upd_frame_q;
  logic [4*N-1:0] upd_digits;

  // One clock: drive inputs just after an edge, compare just after the next one
  task automatic cycle(input logic [N-1:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    @(posedge clk);
    model_edge(a, s);
    #1;
    compare_model();
    cyc_i++;
    if (update) begin
      n_upd++;
      if (first_upd == 0) first_upd = cyc_i;
      upd_pos_q   = update_pos;
      upd_bad_q   = bad_pattern;
      upd_frame_q = frame_done;
      upd_digits  = digits;
    end
    if (bad_pattern) n_bad++;
    if (frame_done)  n_frame++;
  endtask

  task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
    cyc_i     = 0;
    first_upd = 0;
    n_upd     = 0;
    repeat (n) cycle(a, s);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    compare_model();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [6:0]   s;
    logic [3:0]   exp_d;
    logic         exp_bad;
    int           pos;
  } vec_t;

  vec_t vt [10];
  int   scan_vals [6];
  logic [4*N-1:0] saved;
  int   glitch_upd;

  initial begin
    code_tbl[0] = 7'b1000000; code_tbl[1] = 7'b1111001;
    code_tbl[2] = 7'b0100100; code_tbl[3] = 7'b0110000;
    code_tbl[4] = 7'b0011001; code_tbl[5] = 7'b0010010;
    code_tbl[6] = 7'b0000010; code_tbl[7] = 7'b1111000;
    code_tbl[8] = 7'b0000000; code_tbl[9] = 7'b0010000;

    vt[0] = '{6'b111101, 7'b1010101, 4'hE, 1'b1, 1};
    vt[1] = '{6'b111101, 7'b1111111, 4'hF, 1'b0, 1};
    vt[2] = '{6'b110111, 7'b0000000, 4'h8, 1'b0, 3};
    vt[3] = '{6'b111011, 7'b0010000, 4'h9, 1'b0, 2};
    vt[4] = '{6'b101111, 7'b1111000, 4'h7, 1'b0, 4};
    vt[5] = '{6'b111110, 7'b0000010, 4'h6, 1'b0, 0};
    vt[6] = '{6'b011111, 7'b0011001, 4'h4, 1'b0, 5};
    vt[7] = '{6'b111011, 7'b1000000, 4'h0, 1'b0, 2};
    vt[8] = '{6'b111110, 7'b0110000, 4'h3, 1'b0, 0};
    vt[9] = '{6'b101111, 7'b0111111, 4'hE, 1'b1, 4};

    scan_vals = '{1, 2, 3, 4, 5, 9};

    n_bad = 0; n_frame = 0; upd_pos_q = '0; upd_bad_q = 1'b0;
    upd_frame_q = 1'b0; upd_digits = '0;

    // Power-on reset
    rst = 1'b1;
    an  = '1;
    seg = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_model();
    rst = 1'b0;

    // Idle bus: nothing may happen
    n_bad = 0; n_frame = 0;
    hold('1, '1, 100);
    check("idle_updates", 32'(n_upd), 0);
    check("idle_bad",     32'(n_bad), 0);
    check("idle_frames",  32'(n_frame), 0);
    check("idle_digits",  32'(digits), 32'h00FFFFFF);
    check("idle_valid",   32'(digit_valid), 0);

    // Single position, latency and one-shot capture
    hold(6'b111110, 7'b0100100, 12);
    check("lat_first_upd", 32'(first_upd), 6);
    check("lat_n_upd",     32'(n_upd), 1);
    check("lat_pos",       32'(upd_pos_q), 0);
    check("lat_digit",     32'(upd_digits[3:0]), 2);
    check("lat_valid",     32'(digit_valid), 32'b000001);

    // Full scan, twice, frame_done with the last position
    do_reset(2);
    n_frame = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < N; p++) begin
        logic [N-1:0] a;
        a = '1;
        a[p] = 1'b0;
        hold(a, code_tbl[scan_vals[p]], 8);
        check("scan_first_upd", 32'(first_upd), 6);
        check("scan_pos",       32'(upd_pos_q), 32'(p));
        check("scan_frame_flag", 32'(upd_frame_q), (p == N - 1) ? 1 : 0);
      end
      check("scan_digits", 32'(digits), 32'h00954321);
      check("scan_frames", 32'(n_frame), 32'(rep + 1));
    end

    // Table-driven decode vectors
    for (int i = 0; i < 10; i++) begin
      hold(vt[i].a, vt[i].s, 8);
      check("tbl_first_upd", 32'(first_upd), 6);
      check("tbl_pos",       32'(upd_pos_q), 32'(vt[i].pos));
      check("tbl_bad",       32'(upd_bad_q), 32'(vt[i].exp_bad));
      check("tbl_digit",     32'(upd_digits[4*vt[i].pos +: 4]), 32'(vt[i].exp_d));
    end

    // Short glitch during a held dwell, then two anodes low
    hold(6'b111110, code_tbl[7], 8);
    saved = digits;
    hold(6'b111110, 7'b0000000, 3);
    glitch_upd = n_upd;
    hold(6'b111100, 7'b0000000, 20);
    glitch_upd += n_upd;
    check("glitch_updates", 32'(glitch_upd), 0);
    check("glitch_digits",  32'(digits), 32'(saved));

    // Reset partway into a dwell
    hold(6'b111011, code_tbl[3], 2);
    do_reset(1);
    check("rst_digits", 32'(digits), 32'h00FFFFFF);
    check("rst_valid",  32'(digit_valid), 0);
    hold(6'b111011, code_tbl[3], 10);
    check("rst_first_upd", 32'(first_upd), 6);
    check("rst_n_upd",     32'(n_upd), 1);
    check("rst_digit",     32'(digits[11:8]), 3);

    // Randomized dwells against the model
    for (int d = 0; d < 300; d++) begin
      logic [N-1:0] a;
      logic [6:0]   s;
      int kind, len, r;
      if (d == 150) do_reset(2);
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 10);
      a = '1;
      if (kind < 7) a[$urandom_range(0, N - 1)] = 1'b0;
      else if (kind == 7) a = N'($urandom);
      else if (kind == 8) begin
        a[$urandom_range(0, 2)] = 1'b0;
        a[$urandom_range(3, N - 1)] = 1'b0;
      end
      r = $urandom_range(0, 11);
      if (r < 10)       s = code_tbl[r];
      else if (r == 10) s = 7'b1111111;
      else              s = 7'($urandom);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) cycle(a, s ^ 7'(1 << $urandom_range(0, 6)));
        else                            cycle(a, s);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
